// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity checker.
//   state_t : frame receiver FSM states
//   cnt_w() : width of a counter that must hold the values 0..n
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Parameterised reduction XOR.
// Ports:
//   i_vec [W-1:0] : input vector
//   o_xor         : XOR of every bit of i_vec
module xor_gate #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_vec,
    output logic         o_xor
);

    assign o_xor = ^i_vec;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: N data bits (LSB first) then one parity bit.
// Reassembles the data word, checks parity and keeps a saturating count
// of parity failures.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a new frame (aborts any frame in progress)
//   bit_in       : serial data/parity bit
//   bit_valid    : bit_in is valid this cycle
//   clr_err      : synchronous clear of err_count (wins over increment)
//   data_out     : data word of the last completed frame
//   parity_ok    : parity result of the last completed frame
//   frame_valid  : one-cycle strobe when data_out/parity_ok update
//   busy         : frame in progress
//   err_count    : saturating parity failure count
//
// state  | meaning
// IDLE   | waiting for start; bit_valid ignored
// DATA   | shifting in data bits, r_cnt counts bits received
// PARITY | waiting for the parity bit, then result and back to IDLE
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int N          = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clr_err,
    output logic [N-1:0]         data_out,
    output logic                 parity_ok,
    output logic                 frame_valid,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int          CW       = cnt_w(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t                 r_state;
    logic [N-1:0]           r_shift;
    logic [CW-1:0]          r_cnt;
    logic [N-1:0]           r_data;
    logic                   r_parity_ok;
    logic                   r_frame_valid;
    logic                   r_busy;
    logic [ERR_CNT_W-1:0]   r_err;

    logic [N-1:0]           w_shift_next;
    logic                   w_xor;
    logic                   w_frame_done;
    logic                   w_parity_good;

    // New bits enter at the top so the first bit received ends up in bit 0.
    generate
        if (N == 1) begin : g_shift_1
            assign w_shift_next = bit_in;
        end else begin : g_shift_n
            assign w_shift_next = {bit_in, r_shift[N-1:1]};
        end
    endgenerate

    xor_gate #(
        .W (N + 1)
    ) u_xor (
        .i_vec (({bit_in, r_shift})),
        .o_xor (w_xor)
    );

    assign w_parity_good = (w_xor == ODD_PARITY);
    // start has priority over the parity bit, so an abort never completes a frame.
    assign w_frame_done  = (r_state == PARITY) && bit_valid && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_parity_ok   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= '0;
        end else begin
            r_frame_valid <= 1'b0;

            if (start) begin
                r_state <= DATA;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                    end
                    DATA: begin
                        if (bit_valid) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + CW'(1);
                            if (r_cnt == LAST_BIT) begin
                                r_state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_valid) begin
                            r_data        <= r_shift;
                            r_parity_ok   <= w_parity_good;
                            r_frame_valid <= 1'b1;
                            r_state       <= IDLE;
                            r_busy        <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            if (clr_err) begin
                r_err <= '0;
            end else if (w_frame_done && !w_parity_good && (r_err != '1)) begin
                r_err <= r_err + ERR_CNT_W'(1);
            end
        end
    end

    assign data_out    = r_data;
    assign parity_ok   = r_parity_ok;
    assign frame_valid = r_frame_valid;
    assign busy        = r_busy;
    assign err_count   = r_err;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker. Three instances share one stimulus:
//   u_even : N=8, even parity, 8-bit error counter
//   u_odd  : N=8, odd parity,  8-bit error counter
//   u_sat  : N=8, even parity, 2-bit error counter
// The reference model collects received bits in a queue and evaluates each
// completed frame with plain arithmetic.
module tb_serial_parity_checker;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    logic start;
    logic bit_in;
    logic bit_valid;
    logic clr_err;

    logic [N-1:0] data0, data1, data2;
    logic         ok0, ok1, ok2;
    logic         fv0, fv1, fv2;
    logic         busy0, busy1, busy2;
    logic [7:0]   err0, err1;
    logic [1:0]   err2;

    serial_parity_checker #(.N(N), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .clr_err(clr_err), .data_out(data0),
        .parity_ok(ok0), .frame_valid(fv0), .busy(busy0), .err_count(err0)
    );

    serial_parity_checker #(.N(N), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .clr_err(clr_err), .data_out(data1),
        .parity_ok(ok1), .frame_valid(fv1), .busy(busy1), .err_count(err1)
    );

    serial_parity_checker #(.N(N), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .clr_err(clr_err), .data_out(data2),
        .parity_ok(ok2), .frame_valid(fv2), .busy(busy2), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_active;
    bit         m_bits[$];
    bit [N-1:0] exp_data;
    bit         exp_ok_even, exp_ok_odd;
    bit         exp_fv;
    int         exp_err0, exp_err1, exp_err2;
    int         exp_fv_cnt;

    int act_fv_cnt = 0;
    always @(negedge clk) if (rst_n && fv0) act_fv_cnt++;

    task automatic model_reset();
        m_active    = 0;
        m_bits.delete();
        exp_data    = '0;
        exp_ok_even = 0;
        exp_ok_odd  = 0;
        exp_fv      = 0;
        exp_err0    = 0;
        exp_err1    = 0;
        exp_err2    = 0;
    endtask

    // Drive one clock cycle of inputs and advance the model to match.
    task automatic tick(input bit s, input bit bv, input bit b, input bit clr);
        bit done;
        int ones;
        start     = s;
        bit_valid = bv;
        bit_in    = b;
        clr_err   = clr;
        done      = 0;
        if (s) begin
            m_bits.delete();
            m_active = 1;
        end else if (m_active && bv) begin
            m_bits.push_back(b);
            if (m_bits.size() == N + 1) begin
                ones = 0;
                exp_data = '0;
                for (int i = 0; i < N; i++) exp_data += N'(int'(m_bits[i])) << i;
                for (int i = 0; i <= N; i++) ones += int'(m_bits[i]);
                exp_ok_even = (ones % 2 == 0);
                exp_ok_odd  = (ones % 2 == 1);
                m_active = 0;
                done = 1;
                exp_fv_cnt++;
            end
        end
        exp_fv = done;
        if (clr) begin
            exp_err0 = 0; exp_err1 = 0; exp_err2 = 0;
        end else if (done) begin
            if (!exp_ok_even && exp_err0 < 255) exp_err0++;
            if (!exp_ok_odd  && exp_err1 < 255) exp_err1++;
            if (!exp_ok_even && exp_err2 < 3)   exp_err2++;
        end
        @(posedge clk);
        #1;
    endtask

    // start, N data bits LSB first with optional gaps, then the parity bit;
    // clr_last asserts clr_err together with the parity bit.
    task automatic send_frame(input bit [N-1:0] d, input bit p, input int gap, input bit clr_last);
        tick(1, 1, 1, 0);
        for (int i = 0; i <= N; i++) begin
            for (int g = 0; g < gap; g++) tick(0, 0, 1'($urandom), 0);
            if (i < N) tick(0, 1, d[i], 0);
            else       tick(0, 1, p, clr_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; bit_in = 0; bit_valid = 0; clr_err = 0;
        model_reset();
        exp_fv_cnt = 0;
        #12;
        checks++;
        if ({data0, ok0, fv0, busy0, err0} !== '0) begin
            errors++; $display("FAIL reset_values: got data=%h ok=%b fv=%b busy=%b err=%0d, need all 0", data0, ok0, fv0, busy0, err0);
        end
        rst_n = 1;
        send_frame(8'hA5, 1'b1, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (data0 !== 8'hA5 || err0 !== 8'd1) begin
            errors++; $display("FAIL reset_preframe: got data=%h err=%0d, need a5 1", data0, err0);
        end
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0); tick(0, 1, 0, 0); tick(0, 1, 1, 0);
        #3 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({data0, ok0, fv0, busy0, err0, err2} !== '0) begin
            errors++; $display("FAIL reset_async: got data=%h ok=%b fv=%b busy=%b err=%0d, need all 0", data0, ok0, fv0, busy0, err0);
        end
        #2 rst_n = 1;
        exp_fv_cnt = act_fv_cnt;
        for (int i = 0; i < 12; i++) tick(0, 1, 1'($urandom), 0);
        checks++;
        if (busy0 !== 1'b0 || act_fv_cnt !== exp_fv_cnt) begin
            errors++; $display("FAIL reset_release: got busy=%b strobes=%0d, need 0 %0d", busy0, act_fv_cnt, exp_fv_cnt);
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 0, 0);
        checks++;
        if (fv0 !== 1'b1 || data0 !== 8'hA5 || ok0 !== 1'b1 || err0 !== 8'(exp_err0)) begin
            errors++; $display("FAIL good_frame: got fv=%b data=%h ok=%b err=%0d, need 1 a5 1 %0d", fv0, data0, ok0, err0, exp_err0);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (fv0 !== 1'b0 || busy0 !== 1'b0 || data0 !== 8'hA5) begin
            errors++; $display("FAIL good_after: got fv=%b busy=%b data=%h, need 0 0 a5", fv0, busy0, data0);
        end
    endtask

    task automatic test_bad_frame();
        int e0;
        e0 = exp_err0;
        send_frame(8'hA5, 1'b1, 0, 0);
        checks++;
        if (fv0 !== 1'b1 || ok0 !== 1'b0 || err0 !== 8'(e0 + 1)) begin
            errors++; $display("FAIL bad_frame_even: got fv=%b ok=%b err=%0d, need 1 0 %0d", fv0, ok0, err0, e0 + 1);
        end
        checks++;
        if (fv1 !== 1'b1 || ok1 !== 1'b1 || data1 !== 8'hA5 || err1 !== 8'(exp_err1)) begin
            errors++; $display("FAIL bad_frame_odd: got fv=%b ok=%b data=%h err=%0d, need 1 1 a5 %0d", fv1, ok1, data1, err1, exp_err1);
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_gapped();
        tick(1, 0, 0, 0);
        for (int i = 0; i <= N; i++) begin
            for (int g = 0; g < 2; g++) begin
                tick(0, 0, 1'($urandom), 0);
                checks++;
                if (busy0 !== 1'b1 || fv0 !== 1'b0) begin
                    errors++; $display("FAIL gapped_busy: bit %0d got busy=%b fv=%b, need 1 0", i, busy0, fv0);
                end
            end
            if (i < N) tick(0, 1, exp_bit_a5(i), 0);
            else       tick(0, 1, 1'b0, 0);
        end
        checks++;
        if (fv0 !== 1'b1 || data0 !== 8'hA5 || ok0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL gapped_result: got fv=%b data=%h ok=%b busy=%b, need 1 a5 1 0", fv0, data0, ok0, busy0);
        end
        tick(0, 0, 0, 0);
    endtask

    function automatic bit exp_bit_a5(input int i);
        bit [7:0] v;
        v = 8'hA5;
        return v[i];
    endfunction

    task automatic test_abort_back_to_back();
        int base;
        bit [7:0] d;
        tick(0, 0, 0, 0);
        base = act_fv_cnt;
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0); tick(0, 1, 1, 0); tick(0, 1, 0, 0);
        d = 8'h3C;
        tick(1, 1, 1, 0);
        for (int i = 0; i < N; i++) tick(0, 1, d[i], 0);
        tick(0, 1, 0, 0);
        checks++;
        if (fv0 !== 1'b1 || data0 !== 8'h3C || ok0 !== 1'b1) begin
            errors++; $display("FAIL abort_frame: got fv=%b data=%h ok=%b, need 1 3c 1", fv0, data0, ok0);
        end
        d = 8'hFF;
        tick(1, 0, 0, 0);
        for (int i = 0; i < N; i++) tick(0, 1, d[i], 0);
        tick(0, 1, 0, 0);
        checks++;
        if (fv0 !== 1'b1 || data0 !== 8'hFF || ok0 !== 1'b1) begin
            errors++; $display("FAIL back_to_back: got fv=%b data=%h ok=%b, need 1 ff 1", fv0, data0, ok0);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (act_fv_cnt - base !== 2) begin
            errors++; $display("FAIL strobe_count: got %0d strobes, need 2", act_fv_cnt - base);
        end
    endtask

    task automatic test_saturation();
        tick(0, 0, 0, 1);
        for (int f = 0; f < 4; f++) send_frame(8'hA5, 1'b1, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (err2 !== 2'd3 || err0 !== 8'd4) begin
            errors++; $display("FAIL saturate: got sat_err=%0d err=%0d, need 3 4", err2, err0);
        end
        send_frame(8'hA5, 1'b1, 0, 1);
        checks++;
        if (err2 !== 2'd0 || err0 !== 8'd0 || fv2 !== 1'b1) begin
            errors++; $display("FAIL clr_priority: got sat_err=%0d err=%0d fv=%b, need 0 0 1", err2, err0, fv2);
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int j, aborts;
        for (int f = 0; f < 40; f++) begin
            aborts = 0;
            tick(1, 1'($urandom), 1'($urandom), ($urandom % 8) == 0);
            j = 0;
            while (j <= N) begin
                for (int g = $urandom % 3; g > 0; g--) begin
                    tick(0, 0, 1'($urandom), ($urandom % 8) == 0);
                    checks++;
                    if (busy0 !== m_active || fv0 !== 1'b0) begin
                        errors++; $display("FAIL random_gap: frame %0d got busy=%b fv=%b, need %b 0", f, busy0, fv0, m_active);
                    end
                end
                if (aborts < 2 && ($urandom % 12) == 0) begin
                    tick(1, 1, 1'($urandom), 0);
                    aborts++;
                    j = 0;
                end else begin
                    tick(0, 1, 1'($urandom), ($urandom % 8) == 0);
                    j++;
                end
            end
            checks++;
            if (fv0 !== exp_fv || data0 !== exp_data || ok0 !== exp_ok_even || ok1 !== exp_ok_odd || data2 !== exp_data) begin
                errors++; $display("FAIL random_frame: frame %0d got fv=%b data=%h ok=%b/%b, need %b %h %b/%b", f, fv0, data0, ok0, ok1, exp_fv, exp_data, exp_ok_even, exp_ok_odd);
            end
            checks++;
            if (err0 !== 8'(exp_err0) || err1 !== 8'(exp_err1) || err2 !== 2'(exp_err2) || busy0 !== 1'b0) begin
                errors++; $display("FAIL random_err: frame %0d got err=%0d/%0d/%0d busy=%b, need %0d/%0d/%0d 0", f, err0, err1, err2, busy0, exp_err0, exp_err1, exp_err2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_gapped();
        test_abort_back_to_back();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Receives a serial bit stream framed as N data bits (LSB first) followed by one parity bit, then reassembles the data word and checks its parity. It sits downstream of the serial link and feeds the reduction-XOR parity logic with the assembled {parity, data} vector. It presents a one-cycle result strobe and a saturating error count to the control logic.

Parameters:
N, 8, data bits per frame (N >= 1)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
ERR_CNT_W, 8, width of the parity error counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new frame (also aborts a frame in progress)
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is valid this cycle
clr_err  input  1  synchronous clear of err_count
data_out  output  N  last completed frame's data word
parity_ok  output  1  parity result of last completed frame
frame_valid  output  1  one-cycle strobe: data_out/parity_ok updated
busy  output  1  frame in progress (state != IDLE)
err_count  output  ERR_CNT_W  saturating count of parity failures

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE; shift register, bit counter, data_out, parity_ok, frame_valid, busy and err_count all 0.
- FSM states:
  - IDLE: start=1 moves to DATA and clears the bit counter. bit_valid is ignored in IDLE, including the cycle in which start is asserted.
  - DATA: each bit_valid=1 shifts bit_in into the internal shift register (first bit received ends up in data_out[0]) and increments the counter. On the edge that samples the N-th bit, move to PARITY.
  - PARITY: bit_valid=1 samples the parity bit and returns to IDLE. On that same edge:
    - data_out <= shift register;
    - parity_ok <= (XOR of {parity bit, shift register} == ODD_PARITY);
    - frame_valid <= 1.
- Latency: frame_valid is high only in the single cycle after the parity bit is sampled, then returns to 0.
- data_out and parity_ok hold their values until the next frame completes. Aborted frames never update them.
- Gaps: cycles with bit_valid=0 inside DATA or PARITY leave all state unchanged. There is no timeout.
- start in DATA or PARITY: abort the frame, clear the counter, stay in or enter DATA. No frame_valid is produced and the bit_valid in that cycle is ignored.
- Back-to-back frames: start is accepted in the cycle frame_valid is high, because the FSM is already in IDLE.
- err_count:
  - Increments by 1 on each completed frame with a parity failure.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_err=1 sets it to 0. clr_err takes priority over a simultaneous increment, so the result is 0.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.
- Counter width: $clog2(N+1). Counter compare uses N-1 to detect the last data bit.

Decomposition:
- Shared package parity_pkg holds:
  - state enum {IDLE, DATA, PARITY};
  - function cnt_w(N) = $clog2(N+1).
- One sub-module: xor_gate, the existing parameterised reduction-XOR component. It is instantiated with width N+1 on {bit_in, shift register} to compute the parity result combinationally.
- FSM, counter, shift register and error counter live in serial_parity_checker.

Test Plan:
- Reset: assert rst_n=0 after 3 data bits -> all outputs 0 asynchronously; after release, busy=0 and no frame_valid until a new start.
- Good frame, N=8, even parity: start, then bits 1,0,1,0,0,1,0,1 (0xA5), parity 0 -> frame_valid high exactly 1 cycle, data_out=0xA5, parity_ok=1, err_count=0, busy=0 afterwards.
- Bad frame: same stream with parity 1 -> parity_ok=0, err_count=1. Then ODD_PARITY=1 with parity 1 -> parity_ok=1.
- Gapped input: 0xA5 frame with 2 idle cycles (bit_valid=0) between every bit -> same result as the good frame; busy stays 1 throughout.
- Abort and back-to-back: start, 3 bits, start again, 0x3C with parity 0 -> exactly one frame_valid, data_out=0x3C, parity_ok=1. Next start in the frame_valid cycle, 0xFF with parity 0 -> second strobe, data_out=0xFF, parity_ok=1.
- Saturation, ERR_CNT_W=2: 4 bad frames -> err_count=3 (held). A 5th bad frame completing in the same cycle as clr_err=1 -> err_count=0.
